// File: rtl/cpu_pkg.sv
// Shared opcode encodings, decode record and control types for the 5-stage core.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    FREEZE   = 2'd3
  } hc_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic       is_ctrl;
  } hc_dec_t;

endpackage

// File: rtl/hazard_decode.sv
// Register-usage decode of one instruction, used for the ID, EXE and MEM slots.
module hazard_decode
  import cpu_pkg::*;
(
  input  logic [31:0] inst,
  output hc_dec_t     dec
);

  logic [6:0] opcode_s;
  logic       unused_s;

  assign opcode_s = inst[6:0];
  assign unused_s = ^{inst[31:25], inst[14:12]};

  // Classify source/destination usage by major opcode
  always_comb begin
    dec     = '0;
    dec.rd  = inst[11:7];
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    case (opcode_s)
      OP_LUI, OP_AUIPC: dec.writes_rd = 1'b1;
      OP_JAL: begin
        dec.writes_rd = 1'b1;
        dec.is_ctrl   = 1'b1;
      end
      OP_JALR: begin
        dec.writes_rd = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.is_ctrl   = 1'b1;
      end
      OP_BRANCH: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.is_ctrl  = 1'b1;
      end
      OP_LOAD: begin
        dec.writes_rd = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.is_load   = 1'b1;
      end
      OP_STORE: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
      end
      OP_OP_IMM: begin
        dec.writes_rd = 1'b1;
        dec.uses_rs1  = 1'b1;
      end
      OP_OP: begin
        dec.writes_rd = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
      end
      default: dec.writes_rd = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: operand forwarding, load-use stall, branch redirect/flush and
// data-memory freeze with an over-long-freeze watchdog.
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 2,
  parameter int FREEZE_TIMEOUT = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic [31:0] exe_inst,
  input  logic [31:0] exe_inst_pc,
  input  logic [31:0] exe_target_pc,
  input  logic [31:0] mem_inst,
  input  logic        dmem_busy,
  output logic [1:0]  exe_rs1_forward,
  output logic [1:0]  exe_rs2_forward,
  output logic        stall_front,
  output logic        bubble_exe,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        freeze_cpu,
  output logic        freeze_timeout
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  hc_dec_t          id_dec_s, exe_dec_s, mem_dec_s;
  hc_state_e        state_r, saved_state_r, eff_state_s;
  logic [FC_W-1:0]  flush_cnt_r;
  logic [CNT_W-1:0] freeze_cnt_r;
  logic             freeze_timeout_r;
  fwd_sel_e         rs1_fwd_r, rs2_fwd_r, rs1_fwd_s, rs2_fwd_s;
  logic             active_s, load_use_s, redirect_cond_s;
  logic             take_redirect_s, take_lu_s, squash_s;
  logic             unused_s;

  hazard_decode u_dec_id  (.inst(id_inst),  .dec(id_dec_s));
  hazard_decode u_dec_exe (.inst(exe_inst), .dec(exe_dec_s));
  hazard_decode u_dec_mem (.inst(mem_inst), .dec(mem_dec_s));

  assign unused_s = ^{id_dec_s, exe_dec_s, mem_dec_s};

  // Youngest producer wins: EXE match beats MEM match; x0 never matches
  always_comb begin
    rs1_fwd_s = FWD_RF;
    rs2_fwd_s = FWD_RF;
    if (id_valid && id_dec_s.uses_rs1 && (id_dec_s.rs1 != 5'd0)) begin
      if (exe_dec_s.writes_rd && (exe_dec_s.rd == id_dec_s.rs1)) rs1_fwd_s = FWD_EXE;
      else if (mem_dec_s.writes_rd && (mem_dec_s.rd == id_dec_s.rs1)) rs1_fwd_s = FWD_MEM;
      else rs1_fwd_s = FWD_RF;
    end else begin
      rs1_fwd_s = FWD_RF;
    end
    if (id_valid && id_dec_s.uses_rs2 && (id_dec_s.rs2 != 5'd0)) begin
      if (exe_dec_s.writes_rd && (exe_dec_s.rd == id_dec_s.rs2)) rs2_fwd_s = FWD_EXE;
      else if (mem_dec_s.writes_rd && (mem_dec_s.rd == id_dec_s.rs2)) rs2_fwd_s = FWD_MEM;
      else rs2_fwd_s = FWD_RF;
    end else begin
      rs2_fwd_s = FWD_RF;
    end
  end

  assign load_use_s = id_valid && exe_dec_s.is_load && (exe_dec_s.rd != 5'd0) &&
                      ((id_dec_s.uses_rs1 && (id_dec_s.rs1 == exe_dec_s.rd)) ||
                       (id_dec_s.uses_rs2 && (id_dec_s.rs2 == exe_dec_s.rd)));
  assign redirect_cond_s = exe_dec_s.is_ctrl && (exe_target_pc != (exe_inst_pc + 32'd4));

  // On the release cycle of a freeze the pipeline already moves, so act as the saved state
  assign eff_state_s     = (state_r == FREEZE) ? saved_state_r : state_r;
  assign active_s        = !rst && !dmem_busy;
  assign take_redirect_s = active_s && (eff_state_s == RUN) && redirect_cond_s;
  assign take_lu_s       = active_s && (eff_state_s == RUN) && load_use_s && !redirect_cond_s;
  assign squash_s        = take_redirect_s || take_lu_s || (active_s && (eff_state_s == FLUSH));

  assign freeze_cpu      = !rst && dmem_busy;
  assign redirect_valid  = take_redirect_s;
  assign redirect_pc     = take_redirect_s ? exe_target_pc : 32'd0;
  assign stall_front     = take_lu_s;
  assign bubble_exe      = rst || squash_s;
  assign exe_rs1_forward = rs1_fwd_r;
  assign exe_rs2_forward = rs2_fwd_r;
  assign freeze_timeout  = freeze_timeout_r;

  // Sequencer FSM, forward-select registers and freeze watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= RUN;
      saved_state_r    <= RUN;
      flush_cnt_r      <= '0;
      freeze_cnt_r     <= '0;
      freeze_timeout_r <= 1'b0;
      rs1_fwd_r        <= FWD_RF;
      rs2_fwd_r        <= FWD_RF;
    end else if (dmem_busy) begin
      if (freeze_cnt_r != {CNT_W{1'b1}}) freeze_cnt_r <= freeze_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (freeze_cnt_r >= CNT_W'(FREEZE_TIMEOUT - 1)) freeze_timeout_r <= 1'b1;
      if (state_r != FREEZE) begin
        saved_state_r <= state_r;
        state_r       <= FREEZE;
      end
    end else begin
      freeze_cnt_r <= '0;
      rs1_fwd_r    <= squash_s ? FWD_RF : rs1_fwd_s;
      rs2_fwd_r    <= squash_s ? FWD_RF : rs2_fwd_s;
      case (eff_state_s)
        RUN: begin
          if (take_redirect_s) begin
            state_r     <= FLUSH;
            flush_cnt_r <= FC_W'(FLUSH_CYCLES);
          end else if (take_lu_s) begin
            state_r <= LU_STALL;
          end else begin
            state_r <= RUN;
          end
        end
        LU_STALL: state_r <= RUN;
        FLUSH: begin
          flush_cnt_r <= flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
          state_r     <= (flush_cnt_r <= FC_W'(1)) ? RUN : FLUSH;
        end
        default: state_r <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scenario bench for hazard_controller; expected forward selects go through a scoreboard queue.
module tb_hazard_controller;
  import cpu_pkg::*;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5      = 32'h0070_0293; // addi x5,x0,7
  localparam logic [31:0] ADDI_X2      = 32'h0070_0113; // addi x2,x0,7
  localparam logic [31:0] ADDI_X0      = 32'h0070_0013; // addi x0,x0,7
  localparam logic [31:0] ADD_X6_X5_X5 = 32'h0052_8333;
  localparam logic [31:0] ADD_X6_X5_X2 = 32'h0022_8333;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] SUB_X7_X5_X1 = 32'h4012_83B3;
  localparam logic [31:0] LW_X5        = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] BEQ          = 32'h0000_0063;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst, exe_inst, exe_inst_pc, exe_target_pc, mem_inst;
  logic        id_valid, dmem_busy;
  logic [1:0]  exe_rs1_forward, exe_rs2_forward;
  logic        stall_front, bubble_exe, redirect_valid, freeze_cpu, freeze_timeout;
  logic [31:0] redirect_pc;
  logic [3:0]  ctl;

  typedef struct {
    logic [1:0] rs1;
    logic [1:0] rs2;
  } fwd_exp_t;

  typedef struct {
    logic [31:0] id;
    logic        idv;
    logic [31:0] exe;
    logic [31:0] mem;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
  } fwd_case_t;

  fwd_exp_t fwd_q[$];
  fwd_exp_t exp_f;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {stall_front, bubble_exe, redirect_valid, freeze_cpu};

  hazard_controller dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
    .exe_inst(exe_inst), .exe_inst_pc(exe_inst_pc), .exe_target_pc(exe_target_pc),
    .mem_inst(mem_inst), .dmem_busy(dmem_busy),
    .exe_rs1_forward(exe_rs1_forward), .exe_rs2_forward(exe_rs2_forward),
    .stall_front(stall_front), .bubble_exe(bubble_exe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .freeze_cpu(freeze_cpu), .freeze_timeout(freeze_timeout)
  );

  task automatic drive(input logic [31:0] id, input logic idv, input logic [31:0] exe,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] mem,
                       input logic busy);
    id_inst = id; id_valid = idv; exe_inst = exe; exe_inst_pc = pc;
    exe_target_pc = tgt; mem_inst = mem; dmem_busy = busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(NOP, 1'b1, NOP, 32'd0, 32'd0, NOP, 1'b0);
    tick();
    drive(NOP, 1'b1, NOP, 32'd0, 32'd0, NOP, 1'b0);
    checks++;
    if ({ctl, redirect_pc} !== {4'b0100, 32'd0}) begin
      failures++;
      $display("FAIL reset_ctl: got ctl=%b pc=%h expected ctl=0100 pc=0", ctl, redirect_pc);
    end
    checks++;
    if ({exe_rs1_forward, exe_rs2_forward, freeze_timeout} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_regs: got fwd=%0d/%0d to=%b expected 0/0 0",
               exe_rs1_forward, exe_rs2_forward, freeze_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    fwd_case_t tbl[6];
    tbl[0] = '{ADD_X6_X5_X5, 1'b1, ADDI_X5, NOP,     2'd1, 2'd1};
    tbl[1] = '{SUB_X7_X5_X1, 1'b1, NOP,     ADDI_X5, 2'd2, 2'd0};
    tbl[2] = '{ADD_X6_X0_X0, 1'b1, ADDI_X0, ADDI_X0, 2'd0, 2'd0};
    tbl[3] = '{ADD_X6_X5_X5, 1'b1, ADDI_X5, ADDI_X5, 2'd1, 2'd1};
    tbl[4] = '{ADD_X6_X5_X5, 1'b0, ADDI_X5, NOP,     2'd0, 2'd0};
    tbl[5] = '{ADD_X6_X5_X2, 1'b1, NOP,     ADDI_X2, 2'd0, 2'd2};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].id, tbl[i].idv, tbl[i].exe, 32'd0, 32'd4, tbl[i].mem, 1'b0);
      checks++;
      if (ctl !== 4'b0000) begin
        failures++;
        $display("FAIL fwd_ctl[%0d]: got ctl=%b expected 0000", i, ctl);
      end
      fwd_q.push_back('{tbl[i].rs1, tbl[i].rs2});
      tick();
      exp_f = fwd_q.pop_front();
      checks++;
      if ({exe_rs1_forward, exe_rs2_forward} !== {exp_f.rs1, exp_f.rs2}) begin
        failures++;
        $display("FAIL fwd[%0d]: got %0d/%0d expected %0d/%0d", i,
                 exe_rs1_forward, exe_rs2_forward, exp_f.rs1, exp_f.rs2);
      end
    end
  endtask

  task automatic test_load_use();
    drive(ADD_X6_X5_X2, 1'b1, LW_X5, 32'd0, 32'd4, NOP, 1'b0);
    checks++;
    if (ctl !== 4'b1100) begin
      failures++;
      $display("FAIL lu_stall: got ctl=%b expected 1100", ctl);
    end
    fwd_q.push_back('{2'd0, 2'd0});
    tick();
    exp_f = fwd_q.pop_front();
    checks++;
    if ({exe_rs1_forward, exe_rs2_forward} !== {exp_f.rs1, exp_f.rs2}) begin
      failures++;
      $display("FAIL lu_bubble_fwd: got %0d/%0d expected %0d/%0d",
               exe_rs1_forward, exe_rs2_forward, exp_f.rs1, exp_f.rs2);
    end
    drive(ADD_X6_X5_X2, 1'b1, NOP, 32'd0, 32'd4, LW_X5, 1'b0);
    checks++;
    if (ctl !== 4'b0000) begin
      failures++;
      $display("FAIL lu_release: got ctl=%b expected 0000", ctl);
    end
    fwd_q.push_back('{2'd2, 2'd0});
    tick();
    exp_f = fwd_q.pop_front();
    checks++;
    if ({exe_rs1_forward, exe_rs2_forward} !== {exp_f.rs1, exp_f.rs2}) begin
      failures++;
      $display("FAIL lu_fwd_mem: got %0d/%0d expected %0d/%0d",
               exe_rs1_forward, exe_rs2_forward, exp_f.rs1, exp_f.rs2);
    end
  endtask

  task automatic test_redirect();
    drive(ADD_X6_X5_X5, 1'b1, BEQ, 32'h100, 32'hF0, NOP, 1'b0);
    checks++;
    if ({ctl, redirect_pc} !== {4'b0110, 32'hF0}) begin
      failures++;
      $display("FAIL redirect_pulse: got ctl=%b pc=%h expected 0110 pc=f0", ctl, redirect_pc);
    end
    fwd_q.push_back('{2'd0, 2'd0});
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_f = fwd_q.pop_front();
      checks++;
      if ({exe_rs1_forward, exe_rs2_forward} !== {exp_f.rs1, exp_f.rs2}) begin
        failures++;
        $display("FAIL flush_fwd[%0d]: got %0d/%0d expected %0d/%0d", i,
                 exe_rs1_forward, exe_rs2_forward, exp_f.rs1, exp_f.rs2);
      end
      // MEM producer would forward 2 unless the flush squashes it
      drive(ADD_X6_X5_X5, 1'b1, NOP, 32'd0, 32'd4, ADDI_X5, 1'b0);
      checks++;
      if (ctl !== ((i < 2) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL flush_bubble[%0d]: got ctl=%b expected %b", i, ctl,
                 (i < 2) ? 4'b0100 : 4'b0000);
      end
      if (i < 2) fwd_q.push_back('{2'd0, 2'd0});
      else fwd_q.push_back('{2'd2, 2'd2});
      tick();
    end
    exp_f = fwd_q.pop_front();
    checks++;
    if ({exe_rs1_forward, exe_rs2_forward} !== {exp_f.rs1, exp_f.rs2}) begin
      failures++;
      $display("FAIL post_flush_fwd: got %0d/%0d expected %0d/%0d",
               exe_rs1_forward, exe_rs2_forward, exp_f.rs1, exp_f.rs2);
    end
    drive(NOP, 1'b1, BEQ, 32'h100, 32'h104, NOP, 1'b0);
    checks++;
    if ({ctl, redirect_pc} !== {4'b0000, 32'd0}) begin
      failures++;
      $display("FAIL not_taken: got ctl=%b pc=%h expected 0000 pc=0", ctl, redirect_pc);
    end
    tick();
  endtask

  task automatic test_freeze();
    drive(ADD_X6_X5_X5, 1'b1, ADDI_X5, 32'd0, 32'd4, NOP, 1'b0);
    fwd_q.push_back('{2'd1, 2'd1});
    tick();
    // Taken branch in EXE while memory is busy: redirect must wait, forwards must hold
    for (int i = 0; i < 2; i++) begin
      exp_f = fwd_q.pop_front();
      checks++;
      if ({exe_rs1_forward, exe_rs2_forward} !== {exp_f.rs1, exp_f.rs2}) begin
        failures++;
        $display("FAIL freeze_hold_fwd[%0d]: got %0d/%0d expected %0d/%0d", i,
                 exe_rs1_forward, exe_rs2_forward, exp_f.rs1, exp_f.rs2);
      end
      drive(ADD_X6_X5_X2, 1'b1, BEQ, 32'h200, 32'h300, NOP, 1'b1);
      checks++;
      if (ctl !== 4'b0001) begin
        failures++;
        $display("FAIL freeze_no_redirect[%0d]: got ctl=%b expected 0001", i, ctl);
      end
      fwd_q.push_back('{2'd1, 2'd1});
      tick();
    end
    void'(fwd_q.pop_front());
    drive(ADD_X6_X5_X2, 1'b1, BEQ, 32'h200, 32'h300, NOP, 1'b0);
    checks++;
    if ({ctl, redirect_pc} !== {4'b0110, 32'h300}) begin
      failures++;
      $display("FAIL freeze_release_redirect: got ctl=%b pc=%h expected 0110 pc=300", ctl, redirect_pc);
    end
    tick();
    drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b1);
      checks++;
      if (ctl !== 4'b0001) begin
        failures++;
        $display("FAIL flush_freeze[%0d]: got ctl=%b expected 0001", i, ctl);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b0);
      checks++;
      if (ctl !== ((i == 0) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL flush_resume[%0d]: got ctl=%b expected %b", i, ctl,
                 (i == 0) ? 4'b0100 : 4'b0000);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b1);
    for (int i = 0; i < 1023; i++) tick();
    checks++;
    if (freeze_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wdog_early: got %b after 1023 busy cycles expected 0", freeze_timeout);
    end
    tick();
    checks++;
    if (freeze_timeout !== 1'b1) begin
      failures++;
      $display("FAIL wdog_fire: got %b after 1024 busy cycles expected 1", freeze_timeout);
    end
    drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b0);
    tick();
    checks++;
    if (freeze_timeout !== 1'b1) begin
      failures++;
      $display("FAIL wdog_sticky: got %b expected 1", freeze_timeout);
    end
  endtask

  task automatic test_reset_mid();
    drive(ADD_X6_X5_X2, 1'b1, LW_X5, 32'd0, 32'd4, NOP, 1'b0);
    tick();
    rst = 1'b1;
    drive(ADD_X6_X5_X2, 1'b1, NOP, 32'd0, 32'd4, LW_X5, 1'b0);
    checks++;
    if ({ctl, redirect_pc} !== {4'b0100, 32'd0}) begin
      failures++;
      $display("FAIL rst_lu_ctl: got ctl=%b pc=%h expected 0100 pc=0", ctl, redirect_pc);
    end
    tick();
    checks++;
    if ({exe_rs1_forward, exe_rs2_forward, freeze_timeout} !== 5'b00000) begin
      failures++;
      $display("FAIL rst_lu_regs: got fwd=%0d/%0d to=%b expected 0/0 0",
               exe_rs1_forward, exe_rs2_forward, freeze_timeout);
    end
    rst = 1'b0;
    drive(ADD_X6_X5_X2, 1'b1, LW_X5, 32'd0, 32'd4, NOP, 1'b0);
    checks++;
    if (ctl !== 4'b1100) begin
      failures++;
      $display("FAIL rst_lu_run: got ctl=%b expected 1100", ctl);
    end
    tick();
    drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b0);
    tick();
    // Freeze inside a flush, then reset: must come back in RUN, not FLUSH
    drive(NOP, 1'b1, BEQ, 32'h100, 32'hF0, NOP, 1'b0);
    tick();
    drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b1);
    tick();
    rst = 1'b1;
    drive(NOP, 1'b1, NOP, 32'd0, 32'd4, NOP, 1'b1);
    checks++;
    if (ctl !== 4'b0100) begin
      failures++;
      $display("FAIL rst_freeze_ctl: got ctl=%b expected 0100", ctl);
    end
    tick();
    rst = 1'b0;
    drive(NOP, 1'b1, BEQ, 32'h100, 32'hF0, NOP, 1'b0);
    checks++;
    if ({ctl, redirect_pc} !== {4'b0110, 32'hF0}) begin
      failures++;
      $display("FAIL rst_freeze_run: got ctl=%b pc=%h expected 0110 pc=f0", ctl, redirect_pc);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    id_inst = NOP; id_valid = 1'b0; exe_inst = NOP; exe_inst_pc = 32'd0;
    exe_target_pc = 32'd4; mem_inst = NOP; dmem_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_freeze();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
